iter_alu: RTL
=============

Name: iter_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds the following operations:
  - NOR, XOR, SRA, SLT, SLTU.
  - Signed overflow flag.
  - Iterative multiply/divide (MULT, MULTU, DIV, DIVU) writing internal HI/LO registers.
- Sits in the EX stage. The pipeline control stalls on busy_o and consumes results on done_o.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- SHAMT_WIDTH, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  operation request; sampled only when busy_o = 0.
- alu_operation_i  input  4  opcode, encoding below.
- a_i  input  WIDTH  operand A (rs).
- b_i  input  WIDTH  operand B (rt/immediate).
- shamt  input  SHAMT_WIDTH  shift amount.
- busy_o  output  1  multi-cycle operation in progress.
- done_o  output  1  one-cycle pulse; alu_data_o, zero_o and overflow_o are valid this cycle.
- alu_data_o  output  WIDTH  registered result.
- zero_o  output  1  registered; high when alu_data_o == 0.
- overflow_o  output  1  registered signed overflow; meaningful for ADD/SUB only.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Opcodes (existing encodings kept):
  - LUI 0000: b << (WIDTH/2).
  - OR 0001.
  - SLL 0010: b << shamt.
  - ADD 0011.
  - SRL 0100: b >> shamt.
  - SUB 0101: a - b.
  - AND 0110.
  - NOR 0111.
  - XOR 1000.
  - SRA 1001: b >>> shamt.
  - SLT 1010: signed, result 1/0.
  - SLTU 1011: unsigned, result 1/0.
  - MULT 1100, MULTU 1101, DIV 1110, DIVU 1111.
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE and the operation in progress is aborted.
  - busy_o, done_o, zero_o, overflow_o = 0.
  - alu_data_o, hi_o, lo_o = 0.
- FSM states: IDLE, CALC, FIX.
- IDLE, start_i = 1 with a single-cycle opcode:
  - Result computed combinationally and registered at the next edge.
  - done_o = 1 for that one cycle (latency 1).
  - FSM stays IDLE, so back-to-back starts give a done_o every cycle.
- IDLE, start_i = 1 with MULT/MULTU/DIV/DIVU:
  - Latch operands, converting to magnitudes for signed ops.
  - busy_o = 1; go to CALC with iteration counter = 0.
- CALC:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring-division step per cycle.
  - Stay WIDTH cycles; the counter wraps WIDTH-1 -> FIX.
- FIX, one cycle:
  - Apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO: MULT → HI:LO = 2*WIDTH product. DIV → LO = quotient, HI = remainder.
  - Set done_o = 1, busy_o = 0 at the next edge; return to IDLE.
  - start_i → done_o latency = WIDTH+2 cycles.
- Multi-cycle result outputs:
  - On done_o, alu_data_o = LO.
  - zero_o reflects LO.
  - overflow_o = 0.
- start_i while busy_o = 1 is ignored; operands and opcode may change freely.
- HI/LO change only in FIX or on reset.
- Between done pulses, alu_data_o, zero_o and overflow_o hold their last value.
- Divide by zero:
  - Completes with the normal latency.
  - LO = all ones; HI = dividend (a_i as latched, original sign).
  - No error flag.
- DIV with most-negative / -1: LO = most-negative, HI = 0. No trap.
- overflow_o:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
  - All other ops: 0.
- Shifts use only shamt. SRA replicates bit WIDTH-1.

Test Plan:
- Reset asserted mid-MULT (cycle 10 of CALC) → busy_o, hi_o, lo_o = 0 immediately (async); a fresh ADD 3+4 then gives done_o next cycle with alu_data_o = 7.
- ADD 0x7FFFFFFF+1 → alu_data_o = 0x80000000, overflow_o = 1, done_o at cycle 1. SUB 5-5 → alu_data_o = 0, zero_o = 1.
- SRA b = 0x80000000, shamt = 4 → 0xF8000000. SRL same inputs → 0x08000000. SLT a = -1, b = 1 → 1. SLTU same → 0. LUI b = 0x1234 → 0x12340000.
- MULT a = -3, b = 7 → busy_o high for WIDTH+1 cycles; done_o at cycle 34; hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFEB. MULTU 0xFFFFFFFF×2 → hi_o = 1, lo_o = 0xFFFFFFFE.
- DIV a = -7, b = 2 → lo_o = -3, hi_o = -1. DIVU a = 9, b = 0 → lo_o = 0xFFFFFFFF, hi_o = 9. start_i pulses during busy_o are ignored (exactly one done_o).
- WIDTH = 16 instance: MULTU 0xFFFF×0xFFFF → hi_o = 0xFFFE, lo_o = 0x0001, done_o at cycle 18. Back-to-back AND/OR/XOR starts → three consecutive done_o pulses with correct results.

Source files
------------

// File: rtl/iter_alu_if.sv
// Request/response bundle between EX-stage control and the iterative ALU.
`timescale 1ns/1ps
interface iter_alu_if #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start_i;
  logic [3:0]             alu_operation_i;
  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy_o;
  logic                   done_o;
  logic [WIDTH-1:0]       alu_data_o;
  logic                   zero_o;
  logic                   overflow_o;
  logic [WIDTH-1:0]       hi_o;
  logic [WIDTH-1:0]       lo_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i, shamt,
    input  busy_o, done_o, alu_data_o, zero_o, overflow_o,
    input  hi_o, lo_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i, shamt,
    output busy_o, done_o, alu_data_o, zero_o, overflow_o,
    output hi_o, lo_o
  );
endinterface

// File: rtl/iter_alu.sv
// Registered EX-stage ALU: 1-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide into HI/LO.
`timescale 1ns/1ps
module iter_alu #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic     clk,
  input  logic     reset,
  iter_alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_LUI  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  localparam logic [SHAMT_WIDTH-1:0] CNT_LAST =
    SHAMT_WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   zero_q;
  logic                   ovf_q;
  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic [WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]       mq_q;
  logic [WIDTH-1:0]       opb_q;
  logic [WIDTH-1:0]       araw_q;
  logic                   is_div_q;
  logic                   neg_q;
  logic                   rneg_q;
  logic                   div0_q;

  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             multi;

  assign op   = bus.alu_operation_i;
  assign a    = bus.a_i;
  assign b    = bus.b_i;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    res   = '0;
    ovf   = 1'b0;
    multi = 1'b0;
    unique case (op)
      OP_LUI:  res = b << (WIDTH / 2);
      OP_OR:   res = a | b;
      OP_SLL:  res = b << bus.shamt;
      OP_ADD: begin
        res = sum;
        ovf = (a[MSB] == b[MSB]) &&
              (sum[MSB] != a[MSB]);
      end
      OP_SRL:  res = b >> bus.shamt;
      OP_SUB: begin
        res = diff;
        ovf = (a[MSB] != b[MSB]) &&
              (diff[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_SRA:  res = $signed(b) >>> bus.shamt;
      OP_SLT:
        res = {{(WIDTH-1){1'b0}},
               ($signed(a) < $signed(b))};
      OP_SLTU:
        res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: multi = 1'b1;
    endcase
  end

  // MULT and DIV (bit 0 clear) work on magnitudes; signs fixed in FIX
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & a[MSB];
  assign b_neg  = sgn_op & b[MSB];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mq_d;

  assign mul_sum  = {1'b0, acc_q} +
                    (mq_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {acc_q, mq_q[MSB]};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    acc_d = mul_sum[WIDTH:1];
    mq_d  = {mul_sum[0], mq_q[MSB:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_d = div_diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_sh[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign prod = {acc_q, mq_q};

  always_comb begin
    prod_n = neg_q ? -prod : prod;
    fix_hi = prod_n[2*WIDTH-1:WIDTH];
    fix_lo = prod_n[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi = araw_q;
        fix_lo = '1;
      end else begin
        fix_lo = neg_q ? -mq_q : mq_q;
        fix_hi = rneg_q ? -acc_q : acc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (multi) begin
              acc_q    <= '0;
              mq_q     <= a_mag;
              opb_q    <= b_mag;
              araw_q   <= a;
              is_div_q <= op[1];
              neg_q    <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
              div0_q   <= (b == '0);
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= CALC;
            end else begin
              data_q <= res;
              zero_q <= (res == '0);
              ovf_q  <= ovf;
              done_q <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          data_q  <= fix_lo;
          zero_q  <= (fix_lo == '0);
          ovf_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.alu_data_o = data_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
endmodule
